// File: rtl/sram_pkg.sv
// Shared types and helpers for the pre-neuron state SRAM: clear-sequencer state
// encoding and the byte-merge used for write data and same-address read bypass.
package sram_pkg;

   typedef enum logic [1:0] {RESET_CLR, IDLE, CLR} clr_state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

   // merge works on a fixed wide word so any DATA_WIDTH up to this fits via casts
   localparam int MAX_DATA_WIDTH = 256;
   localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   function automatic logic [MAX_DATA_WIDTH-1:0] merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BE_WIDTH-1:0]   be
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < MAX_BE_WIDTH; i++) begin
         if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// Clear sequencer: sweeps every word once after reset or on request, one word
// per cycle, and flags BUSY for the whole sweep.
module sram_clr_seq
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int SRAM_DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_req,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  clr_we
);

   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(SRAM_DEPTH - 1);

   clr_state_t            state_reg;
   logic [ADDR_WIDTH:0]   cnt_reg;
   logic                  busy_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= RESET_CLR;
         cnt_reg   <= '0;
         busy_reg  <= 1'b1;
      end else begin
         case (state_reg)
            RESET_CLR, CLR: begin
               if (cnt_reg == LAST_ADDR) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state_reg <= CLR;
                  busy_reg  <= 1'b1;
                  cnt_reg   <= '0;
               end
            end
            default: begin
               state_reg <= RESET_CLR;
               busy_reg  <= 1'b1;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign clr_we   = busy_reg;
   assign clr_addr = cnt_reg[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sram_pre_neuron_sdp.sv
// Simple-dual-port pre-neuron state memory with byte enables and clear sweep.
// Define SRAM_PRE_NEURON_BYPASS_EN for write-first same-address read; default is read-first.
module sram_pre_neuron_sdp
   import sram_pkg::*;
#(
   parameter int                  ADDR_WIDTH = 8,
   parameter int                  DATA_WIDTH = 32,
   parameter int                  SRAM_DEPTH = 256,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                    CK,
   input  logic                    RST_N,
   input  logic                    RE,
   input  logic [ADDR_WIDTH-1:0]   RA,
   output logic [DATA_WIDTH-1:0]   RQ,
   output logic                    RQ_VALID,
   input  logic                    WE,
   input  logic [ADDR_WIDTH-1:0]   WA,
   input  logic [DATA_WIDTH-1:0]   WD,
   input  logic [DATA_WIDTH/8-1:0] WBE,
   input  logic                    CLR_REQ,
   output logic                    BUSY
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(SRAM_DEPTH);

   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  clr_we;

   logic                  ra_ok, wa_ok, rd_fire;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BE_W-1:0]       wr_be;
   logic [DATA_WIDTH-1:0] rd_raw;
   logic [DATA_WIDTH-1:0] rq_word;
   logic                  rd_zero_reg;
   logic                  rq_valid_reg;

   sram_clr_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SRAM_DEPTH (SRAM_DEPTH)
   ) u_clr_seq (
      .clk      (CK),
      .rst_n    (RST_N),
      .clr_req  (CLR_REQ),
      .busy     (BUSY),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );

   assign ra_ok   = {1'b0, RA} < DEPTH_C;
   assign wa_ok   = {1'b0, WA} < DEPTH_C;
   assign rd_fire = !BUSY && RE;

   // Sweep owns the write port while busy; user bytes outside WBE carry INIT but are not written.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = clr_addr;
      wr_be   = '1;
      wr_data = INIT_VALUE;
      if (clr_we) begin
         wr_en = 1'b1;
      end else begin
         wr_en   = WE && wa_ok;
         wr_addr = WA;
         wr_be   = WBE;
         wr_data = DATA_WIDTH'(merge(MAX_DATA_WIDTH'(INIT_VALUE), MAX_DATA_WIDTH'(WD),
                                     MAX_BE_WIDTH'(WBE)));
      end
   end

   // One byte-wide array per lane keeps byte enables mappable onto block RAM.
   generate
      for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
         logic [7:0] lane_mem [0:SRAM_DEPTH-1];
         logic [7:0] lane_q_reg;

         always_ff @(posedge CK) begin
            if (wr_en && wr_be[gi]) lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
         end

         always_ff @(posedge CK) begin
            if (rd_fire && ra_ok) lane_q_reg <= lane_mem[RA];
         end

         assign rd_raw[gi*8 +: 8] = lane_q_reg;
      end
   endgenerate

   always_ff @(posedge CK) begin
      if (!RST_N) begin
         rd_zero_reg  <= 1'b1;
         rq_valid_reg <= 1'b0;
      end else begin
         rq_valid_reg <= rd_fire;
         if (rd_fire) rd_zero_reg <= !ra_ok;
      end
   end

`ifdef SRAM_PRE_NEURON_BYPASS_EN
   logic [BE_W-1:0]       byp_be_reg;
   logic [DATA_WIDTH-1:0] byp_wd_reg;

   // Collision bytes are captured and overlaid on the RAM's read-first output.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         byp_be_reg <= '0;
         byp_wd_reg <= '0;
      end else if (rd_fire) begin
         byp_be_reg <= (WE && (WA == RA) && ra_ok) ? WBE : '0;
         byp_wd_reg <= WD;
      end
   end

   assign rq_word = DATA_WIDTH'(merge(MAX_DATA_WIDTH'(rd_raw), MAX_DATA_WIDTH'(byp_wd_reg),
                                      MAX_BE_WIDTH'(byp_be_reg)));
`else
   assign rq_word = rd_raw;
`endif

   assign RQ       = rd_zero_reg ? '0 : rq_word;
   assign RQ_VALID = rq_valid_reg;

endmodule

// File: tb/tb_sram_pre_neuron_sdp.sv
// Self-checking bench: directed and random traffic against an array model, plus a
// second 200-word instance for out-of-range behaviour.
module tb_sram_pre_neuron_sdp;

   localparam int          DEPTH   = 256;
   localparam int          DEPTH_B = 200;
   localparam logic [31:0] INIT_B  = 32'hC0FFEE11;

   logic        CK = 1'b0;
   logic        RST_N = 1'b0;
   logic        RE = 1'b0, WE = 1'b0, CLR_REQ = 1'b0;
   logic [7:0]  RA = '0, WA = '0;
   logic [31:0] WD = '0;
   logic [3:0]  WBE = '0;
   logic [31:0] RQ;
   logic        RQ_VALID, BUSY;

   logic        b_re = 1'b0, b_we = 1'b0, b_clr = 1'b0;
   logic [7:0]  b_ra = '0, b_wa = '0;
   logic [31:0] b_wd = '0;
   logic [3:0]  b_wbe = '0;
   logic [31:0] b_rq;
   logic        b_valid, b_busy;

   int vectors = 0;
   int miscompares = 0;
   int b_idle_at = -1;

   logic [31:0] model_mem [0:DEPTH-1];
   logic [31:0] model_rq = '0;

   always #5 CK = ~CK;

   sram_pre_neuron_sdp #(
      .ADDR_WIDTH (8), .DATA_WIDTH (32), .SRAM_DEPTH (DEPTH), .INIT_VALUE (32'h0)
   ) dut (
      .CK (CK), .RST_N (RST_N), .RE (RE), .RA (RA), .RQ (RQ), .RQ_VALID (RQ_VALID),
      .WE (WE), .WA (WA), .WD (WD), .WBE (WBE), .CLR_REQ (CLR_REQ), .BUSY (BUSY)
   );

   sram_pre_neuron_sdp #(
      .ADDR_WIDTH (8), .DATA_WIDTH (32), .SRAM_DEPTH (DEPTH_B), .INIT_VALUE (INIT_B)
   ) dut_b (
      .CK (CK), .RST_N (RST_N), .RE (b_re), .RA (b_ra), .RQ (b_rq), .RQ_VALID (b_valid),
      .WE (b_we), .WA (b_wa), .WD (b_wd), .WBE (b_wbe), .CLR_REQ (b_clr), .BUSY (b_busy)
   );

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic step(input logic re, input logic [7:0] ra, input logic we, input logic [7:0] wa,
                       input logic [31:0] wd, input logic [3:0] wbe, input logic clr);
      logic [31:0] exp_rq;
      RE = re; RA = ra; WE = we; WA = wa; WD = wd; WBE = wbe; CLR_REQ = clr;
      exp_rq = model_rq;
      if (re) begin
         exp_rq = model_mem[ra];
`ifdef SRAM_PRE_NEURON_BYPASS_EN
         if (we && wa == ra) exp_rq = byte_merge(model_mem[ra], wd, wbe);
`endif
      end
      if (we) model_mem[wa] = byte_merge(model_mem[wa], wd, wbe);
      tick();
      model_rq = exp_rq;
      $display("step re=%0b ra=%0d we=%0b wa=%0d wd=%08h wbe=%h clr=%0b -> rq=%08h v=%0b",
               re, ra, we, wa, wd, wbe, clr, RQ, RQ_VALID);
      check("rq", RQ, exp_rq);
      check("rq_valid", {31'b0, RQ_VALID}, {31'b0, re});
      RE = 1'b0; WE = 1'b0; CLR_REQ = 1'b0;
   endtask

   // Runs until BUSY drops while hammering the user ports, which must all be ignored.
   task automatic wait_idle(input string tag, input int exp_cycles);
      int n;
      int b_at;
      n = 0;
      b_at = -1;
      RE = 1'b1; RA = 8'd3; WE = 1'b1; WA = 8'd9; WD = 32'hDEADBEEF; WBE = 4'hF; CLR_REQ = 1'b1;
      while (BUSY === 1'b1 && n < 1000) begin
         tick();
         n++;
         if (b_at < 0 && b_busy === 1'b0) b_at = n;
         if (BUSY === 1'b1) begin
            check({tag, "_valid_busy"}, {31'b0, RQ_VALID}, 32'd0);
            check({tag, "_rq_hold"}, RQ, model_rq);
         end
      end
      RE = 1'b0; WE = 1'b0; CLR_REQ = 1'b0;
      $display("%s: busy for %0d cycles", tag, n);
      check({tag, "_busy_len"}, n, exp_cycles);
      b_idle_at = b_at;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

      // Reset held 3 cycles, then the power-on sweep
      RST_N = 1'b0;
      repeat (3) tick();
      check("rst_busy", {31'b0, BUSY}, 32'd1);
      check("rst_rq", RQ, 32'h0);
      check("rst_valid", {31'b0, RQ_VALID}, 32'd0);
      check("rst_b_busy", {31'b0, b_busy}, 32'd1);
      RST_N = 1'b1;
      wait_idle("reset", DEPTH);
      check("b_busy_len", b_idle_at, DEPTH_B);

      step(1'b1, 8'd0,   1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      step(1'b1, 8'd128, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      step(1'b1, 8'd255, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      step(1'b0, 8'd0,   1'b0, 8'd0, 32'h0, 4'h0, 1'b0);

      // Partial byte write
      step(1'b0, 8'd0, 1'b1, 8'd5, 32'hAABBCCDD, 4'hF, 1'b0);
      step(1'b0, 8'd0, 1'b1, 8'd5, 32'h11223344, 4'h5, 1'b0);
      step(1'b1, 8'd5, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      check("partial_const", RQ, 32'hAA22CC44);

      // Same-address read and write
      step(1'b1, 8'd7, 1'b1, 8'd7, 32'h12345678, 4'hF, 1'b0);
`ifdef SRAM_PRE_NEURON_BYPASS_EN
      check("collision_const", RQ, 32'h12345678);
`else
      check("collision_const", RQ, 32'h0);
`endif
      step(1'b1, 8'd7, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      check("collision_after", RQ, 32'h12345678);

      // Random traffic over a small address window to provoke collisions
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)), 1'b0);
      end

      // Clear request with a concurrent read
      step(1'b0, 8'd0, 1'b1, 8'd3, 32'h00000055, 4'hF, 1'b0);
      step(1'b1, 8'd3, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1);
      check("clr_read_const", RQ, 32'h00000055);
      wait_idle("clr", DEPTH);
      step(1'b1, 8'd9, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      step(1'b1, 8'd3, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 8'd40, 32'hCAFEF00D, 4'hF, 1'b0);
      step(1'b1, 8'd40, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);

      // Reset 100 cycles into a sweep
      step(1'b0, 8'd0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1);
      repeat (100) tick();
      RST_N = 1'b0;
      repeat (2) tick();
      model_rq = 32'h0;
      check("mid_rst_rq", RQ, 32'h0);
      check("mid_rst_busy", {31'b0, BUSY}, 32'd1);
      RST_N = 1'b1;
      wait_idle("midsweep", DEPTH);
      step(1'b1, 8'd40, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);

      // Out-of-range on the 200-word instance
      b_we = 1'b1; b_wa = 8'd210; b_wd = 32'hDEADBEEF; b_wbe = 4'hF;
      tick();
      b_we = 1'b0; b_re = 1'b1; b_ra = 8'd210;
      tick();
      $display("b read 210 -> rq=%08h v=%0b", b_rq, b_valid);
      check("b_oor_rq", b_rq, 32'h0);
      check("b_oor_valid", {31'b0, b_valid}, 32'd1);
      b_ra = 8'd199;
      tick();
      $display("b read 199 -> rq=%08h v=%0b", b_rq, b_valid);
      check("b_last_rq", b_rq, INIT_B);
      b_re = 1'b0; b_we = 1'b1; b_wa = 8'd150; b_wd = 32'h12345678; b_wbe = 4'h3;
      tick();
      b_we = 1'b0; b_re = 1'b1; b_ra = 8'd150;
      tick();
      $display("b read 150 -> rq=%08h v=%0b", b_rq, b_valid);
      check("b_partial_rq", b_rq, 32'hC0FF5678);
      b_re = 1'b0;
      tick();
      check("b_idle_valid", {31'b0, b_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_pre_neuron_sdp.md
# sram_pre_neuron_sdp

Parametrised simple-dual-port pre-neuron state memory for the SNN FF-STDP core; next generation of the single-port pre-neuron SRAM. Separate read and write ports let the neuron-update pipeline read neuron N+1 while writing back neuron N. Per-byte write enables allow partial state updates. A built-in clear sequencer initialises every word after reset or on request, replacing file-based preload.

## Interface
Parameters:
- ADDR_WIDTH, 8, address bits; must satisfy SRAM_DEPTH ≤ 2^ADDR_WIDTH
- DATA_WIDTH, 32, word width; must be a multiple of 8
- SRAM_DEPTH, 256, number of words
- INIT_VALUE, 0, DATA_WIDTH-bit word written by the clear sequencer

Ports (clock and reset first):
- CK  in  1  clock; single clock domain, all logic on its rising edge
- RST_N  in  1  reset; synchronous, active-low
- RE  in  1  read enable
- RA  in  ADDR_WIDTH  read address
- RQ  out  DATA_WIDTH  read data
- RQ_VALID  out  1  RQ updated this cycle
- WE  in  1  write enable
- WA  in  ADDR_WIDTH  write address
- WD  in  DATA_WIDTH  write data
- WBE  in  DATA_WIDTH/8  byte write enables; bit i covers WD[8i+7:8i]
- CLR_REQ  in  1  start a full clear sweep
- BUSY  out  1  clear sweep in progress; user ports ignored

## Operation
- The FSM has three states: RESET_CLR, IDLE, CLR.
- While RST_N is low: state is RESET_CLR, sweep counter is 0, BUSY=1, RQ=0, RQ_VALID=0.
- CLR and RESET_CLR behave identically:
  - One word is written per cycle with INIT_VALUE and all bytes enabled, at address = counter; the counter increments.
  - After writing SRAM_DEPTH-1 the FSM goes to IDLE.
- IDLE, read: RE=1 with RA < SRAM_DEPTH gives RQ=mem[RA] and RQ_VALID=1 on the next edge. RE=1 with RA ≥ SRAM_DEPTH gives RQ=0 and RQ_VALID=1.
- IDLE, read idle: RE=0 holds RQ and gives RQ_VALID=0.
- IDLE, write: WE=1 with WA < SRAM_DEPTH updates only the bytes with WBE set. Out-of-range writes are dropped.
- IDLE, clear request: CLR_REQ=1 enters CLR on the next edge. In that same cycle, RE and WE are still serviced, and the read completes normally.
- While BUSY: RE, WE and CLR_REQ are ignored, RQ holds, RQ_VALID=0.
- Same-address read and write in one cycle: the result is governed by the Configuration macro.
- Reset mid-sweep: the sweep restarts at address 0. Reset mid-read: RQ=0.

## Timing
- Read latency is 1 cycle. Full read and write throughput is one each per cycle.
- Write is visible to a read issued in the following cycle.
- Clear duration is exactly SRAM_DEPTH cycles:
  - After RST_N rises, BUSY is 1 for SRAM_DEPTH cycles and falls on the edge after the last word is written.
  - The first user access is accepted in the cycle BUSY=0.
  - Depth 256 gives 256 busy cycles.
- CLR_REQ accepted at edge t: BUSY=1 from t+1 through t+SRAM_DEPTH, IDLE again at t+SRAM_DEPTH+1.
- Counter width is ADDR_WIDTH+1 bits; it never wraps during a sweep.

## Configuration
- SRAM_PRE_NEURON_BYPASS_EN defined:
  - A same-cycle, same-address RE and WE returns the merged word on RQ.
  - Merged word = WD bytes where WBE is set, old mem bytes elsewhere (write-first).
- Not defined: the same case returns the old word (read-first), matching the previous generation.

## Structure
- Shared package sram_pkg holds:
  - the FSM state enum (RESET_CLR, IDLE, CLR)
  - a byte-merge function merge(old, new, be) used by both the write path and the bypass
  - a localparam BE_WIDTH = DATA_WIDTH/8
- One sub-module, sram_clr_seq:
  - contents: FSM and sweep counter
  - outputs: BUSY, clear write address, clear write strobe
- Top level muxes clear versus user write, and holds the storage array and read register.

## Test plan
- Reset clear: hold RST_N low 3 cycles, release. Expect BUSY=1 for exactly 256 cycles, then reads of addresses 0, 128 and 255 return INIT_VALUE with RQ_VALID one cycle later.
- Partial write: write 0xAABBCCDD to address 5 with WBE=4'b1111. Then write 0x11223344 with WBE=4'b0101. A read of address 5 returns 0xAA22CC44.
- Collision: same cycle, RE with RA=7 and WE with WA=7, WD=0x12345678, WBE=4'hF, old value 0.
  - Bypass build: RQ=0x12345678.
  - Non-bypass build: RQ=0, and a following read returns 0x12345678.
- Clear request: issue CLR_REQ with a concurrent read of address 3 (value 0x55). RQ=0x55, then BUSY for 256 cycles; RE/WE during BUSY have no effect and RQ_VALID stays 0.
- Reset mid-sweep: assert RST_N low at sweep cycle 100, release. BUSY lasts a full 256 cycles from release.
- Out-of-range, SRAM_DEPTH=200: a write to address 210 is dropped. A read of address 210 gives RQ=0 with RQ_VALID=1, and address 199 still reads INIT_VALUE.
